// File: rtl/sigma_delta_dac_multi_if.sv
// Frame handshake bundle between the voice mixer and the multi-channel DAC.
interface sigma_delta_dac_multi_if #(
  parameter int AUDIO_WIDTH  = 8,
  parameter int NUM_CHANNELS = 2
);
  logic [NUM_CHANNELS*AUDIO_WIDTH-1:0] sample_in;
  logic                                sample_valid;
  logic                                sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/sigma_delta_dac_multi.sv
// Multi-channel 1-bit sigma-delta DAC: one-frame holding buffer, shared
// prescaler / sample counter, per-channel first/second-order modulators.

// One modulator lane. Updates only on tick; clr wipes state for an order switch.
module sigma_delta_dac_multi_ch #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         tick,
  input  logic         clr,
  input  logic         ord,
  input  logic [W-1:0] u,
  output logic         dout
);
  localparam int IW = W + 4;
  localparam int EW = W + 6;
  localparam logic signed [EW-1:0] HALF = EW'(2 ** (W - 1));
  localparam logic signed [EW-1:0] IMAX = EW'(2 ** (W + 3) - 1);

  logic        [W:0]    acc, acc_n;
  logic signed [IW-1:0] i1, i2, i1_n, i2_n;
  logic signed [EW-1:0] x, fb, s1, s2;

  // Clamp a wide sum into the integrator range instead of wrapping.
  function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] s);
    if (s > IMAX)       sat = IW'(IMAX);
    else if (s < -IMAX) sat = IW'(-IMAX);
    else                sat = IW'(s);
  endfunction

  // Next-state of both loop flavours; only the selected one is committed.
  always_comb begin
    acc_n = acc + {1'b0, u} - (dout ? {1'b1, {W{1'b0}}} : '0);
    x     = $signed({{(EW-W){1'b0}}, u}) - HALF;
    fb    = dout ? HALF : -HALF;
    s1    = EW'(i1) + x - fb;
    i1_n  = sat(s1);
    s2    = EW'(i2) + EW'(i1_n) - fb;
    i2_n  = sat(s2);
  end

  // Modulator state, advanced once per tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      i1   <= '0;
      i2   <= '0;
      dout <= 1'b0;
    end else if (tick) begin
      if (clr) begin
        acc  <= '0;
        i1   <= '0;
        i2   <= '0;
        dout <= 1'b0;
      end else if (!ord) begin
        acc  <= acc_n;
        dout <= acc_n[W];
      end else begin
        i1   <= i1_n;
        i2   <= i2_n;
        dout <= ~i2_n[IW-1];
      end
    end
  end
endmodule

module sigma_delta_dac_multi #(
  parameter int AUDIO_WIDTH  = 8,
  parameter int NUM_CHANNELS = 2,
  parameter int OSR_DIV      = 4,
  parameter int SAMPLE_TICKS = 64,
  parameter bit SIGNED_IN    = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  sigma_delta_dac_multi_if.slave  s_if,
  input  logic                    order_sel,
  input  logic                    mute,
  input  logic                    clear_underrun,
  output logic                    underrun,
  output logic [NUM_CHANNELS-1:0] dac_out
);
  localparam int W  = AUDIO_WIDTH;
  localparam int PW = (OSR_DIV > 1) ? $clog2(OSR_DIV) : 1;
  localparam int SW = $clog2(SAMPLE_TICKS);
  localparam logic [W-1:0] MID  = {1'b1, {(W-1){1'b0}}};
  // Signed input becomes offset-binary by flipping the sign bit.
  localparam logic [W-1:0] FLIP = SIGNED_IN ? MID : '0;

  logic [PW-1:0] pcnt;
  logic [SW-1:0] scnt;
  logic          tick, boundary;
  logic          full, ord_q, ord_chg;
  logic [NUM_CHANNELS-1:0][W-1:0] hold, act;

  assign tick     = (pcnt == PW'(OSR_DIV - 1));
  assign boundary = tick && (scnt == SW'(SAMPLE_TICKS - 1));
  assign ord_chg  = tick && (order_sel != ord_q);
  assign s_if.sample_ready = ~full;

  // Modulator-rate prescaler.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

  // Audio-sample period counter in modulator ticks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      scnt <= '0;
    else if (boundary) scnt <= '0;
    else if (tick)     scnt <= scnt + SW'(1);
  end

  // Holding buffer / active frame. full is only cleared by a boundary and only
  // set by an accept; accept needs !full so the two never collide, and an
  // accept on an empty boundary lands in holding for the next period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full <= 1'b0;
      hold <= '0;
      act  <= {NUM_CHANNELS{MID}};
    end else if (boundary && full) begin
      for (int c = 0; c < NUM_CHANNELS; c++) act[c] <= hold[c] ^ FLIP;
      full <= 1'b0;
    end else if (s_if.sample_valid && !full) begin
      hold <= s_if.sample_in;
      full <= 1'b1;
    end
  end

  // Sticky underrun; a new underrun wins over a simultaneous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                underrun <= 1'b0;
    else if (boundary && !full)  underrun <= 1'b1;
    else if (clear_underrun)     underrun <= 1'b0;
  end

  // Stored modulator order, resampled every tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ord_q <= 1'b0;
    else if (ord_chg) ord_q <= order_sel;
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [W-1:0] u;
    assign u = mute ? MID : act[c];
    sigma_delta_dac_multi_ch #(.W(W)) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .tick    (tick),
      .clr     (ord_chg),
      .ord     (ord_q),
      .u       (u),
      .dout    (dac_out[c])
    );
  end
endmodule
